data_mem_arbiter: RTL and testbench
===================================

Name: data_mem_arbiter

Overview:
Two-port arbiter in front of the 16 KB data memory block RAM (4096 x 32-bit words). It shares the single-port RAM between the CPU load/store unit (port 0) and a secondary master (port 1: DMA/debug loader). It issues at most one RAM access per cycle and returns read data with a fixed one-cycle latency. It also guards port 1 against starvation and rejects out-of-range addresses.

Parameters:
ADDR_W, 12, RAM word-address width; valid word addresses are 0 .. 2^ADDR_W-1
MAX_WAIT, 8, cycles port 1 may wait with Req_1 high before it preempts port 0 (range 1..255)

Ports:
Clock  in  1  system clock, all state on rising edge
Reset_N  in  1  asynchronous active-low reset
Req_0  in  1  port 0 request; held with Addr_0/We_0/Data_W_0 stable until Ack_0
Addr_0  in  30  port 0 word address
We_0  in  1  port 0: 1 = write, 0 = read
Data_W_0  in  32  port 0 write data
Ack_0  out  1  port 0 request accepted (1-cycle pulse)
Err_0  out  1  port 0 address out of range (pulses with Ack_0)
Rd_Valid_0  out  1  port 0 read data valid (1-cycle pulse)
Data_R_0  out  32  port 0 read data
Req_1, Addr_1, We_1, Data_W_1, Ack_1, Err_1, Rd_Valid_1, Data_R_1  as port 0, for port 1
Mem_Addr  out  ADDR_W  RAM address
Mem_En_R  out  1  RAM read enable
Mem_En_W  out  1  RAM write enable
Mem_Data_W  out  32  RAM write data
Mem_Data_R  in  32  RAM q; valid the cycle after Mem_En_R (registered RAM output)

Behaviour:
- Clock: single domain. Reset: asynchronous, active-low; Reset_N low forces all registered state to its reset value immediately. Deassertion takes effect at the next Clock edge.
- Reset values: Ack_x=0, Err_x=0, Rd_Valid_x=0, Data_R_x=0, Mem_En_R=0, Mem_En_W=0, Mem_Addr=0, Mem_Data_W=0, wait counter=0, pending-read tag=none.
- Grant is combinational each cycle:
  - Default: port 0 has priority.
  - If Req_1=1 and wait counter >= MAX_WAIT, port 1 has priority.
  - A port with Req_x=0 is never granted.
- Ack_x is combinational and equals grant_x. A requester samples Ack_x at the rising edge and drops or changes its request after that edge. Ack_0 and Ack_1 are never both 1.
- Wait counter (8-bit, saturating):
  - Clears whenever port 1 is granted or Req_1=0.
  - Otherwise increments by 1 per cycle with Req_1=1 and Ack_1=0.
- Range check: Addr_x[29:ADDR_W] != 0 is out of range.
  - The request is still granted (Ack_x=1) with Err_x=1 in the same cycle.
  - No RAM enable is asserted.
  - An out-of-range read still produces Rd_Valid_x next cycle with Data_R_x=32'h0.
- Mem_* outputs are combinational from the granted request:
  - Mem_Addr = Addr_g[ADDR_W-1:0].
  - Mem_Data_W = Data_W_g.
  - Mem_En_W = We_g & in-range.
  - Mem_En_R = ~We_g & in-range.
  - When there is no grant, enables are 0 and Mem_Addr/Mem_Data_W hold 0.
- Read return pipeline:
  - On the grant edge, register the tag (port id, read flag, error flag).
  - Next cycle, assert Rd_Valid for the tagged port, with Data_R_x = Mem_Data_R, or 0 if the error flag is set.
  - Data_R_x of the non-returning port holds its last value.
- Throughput: one grant per cycle. Back-to-back reads from either port are allowed. The returned read is always for the previous cycle's grant, so a return can coincide with a new grant.
- Writes produce no Rd_Valid. Read-after-write to the same address in consecutive cycles returns the new data (RAM is written at the grant edge, before the next read).
- Simultaneous Req_0 and Req_1 with counter < MAX_WAIT: port 0 wins and the counter increments.
- Reset mid-operation: a pending read tag is discarded and no Rd_Valid is issued after reset.

Test Plan:
- Reset: hold Reset_N=0 with both Req high -> no Ack, all Mem_En 0. Release -> port 0 is granted first.
- Port 0 writes 32'hDEADBEEF to addr 5, then reads addr 5 -> Ack_0 each cycle, Mem_En_W then Mem_En_R with Mem_Addr=5. Rd_Valid_0 one cycle after the read grant with Data_R_0=32'hDEADBEEF.
- Starvation, MAX_WAIT=8: Req_0 and Req_1 held high continuously -> Ack_0 for 8 cycles, Ack_1 on cycle 9 with counter cleared, then the pattern repeats. Ack_0/Ack_1 are never both high.
- Out-of-range: port 1 reads addr 30'h1000 -> Ack_1=1 and Err_1=1, Mem_En_R=0, next cycle Rd_Valid_1=1 with Data_R_1=0.
- Interleaved reads: port 0 reads addr 1 (value 11), next cycle port 1 reads addr 2 (value 22) -> Rd_Valid_0 with 11, then Rd_Valid_1 with 22 on consecutive cycles with no cross-routing.
- Reset mid-read: assert Reset_N low between a read grant and its return -> no Rd_Valid after reset, Data_R_x=0.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - two-port arbiter for the single-port data memory
// Port 0 has priority unless port 1 has waited MAX_WAIT cycles; reads return one cycle after grant.
module data_mem_arbiter #(
    parameter int ADDR_W   = 12,
    parameter int MAX_WAIT = 8
) (
    input  logic              Clock,
    input  logic              Reset_N,
    input  logic              Req_0,
    input  logic [29:0]       Addr_0,
    input  logic              We_0,
    input  logic [31:0]       Data_W_0,
    output logic              Ack_0,
    output logic              Err_0,
    output logic              Rd_Valid_0,
    output logic [31:0]       Data_R_0,
    input  logic              Req_1,
    input  logic [29:0]       Addr_1,
    input  logic              We_1,
    input  logic [31:0]       Data_W_1,
    output logic              Ack_1,
    output logic              Err_1,
    output logic              Rd_Valid_1,
    output logic [31:0]       Data_R_1,
    output logic [ADDR_W-1:0] Mem_Addr,
    output logic              Mem_En_R,
    output logic              Mem_En_W,
    output logic [31:0]       Mem_Data_W,
    input  logic [31:0]       Mem_Data_R
);

    logic        gnt_0, gnt_1;
    logic        oor_0, oor_1;
    logic        p1_prio;
    logic [7:0]  wait_cnt;
    logic        tag_vld, tag_port, tag_err;
    logic [31:0] hold_0, hold_1;

    // Grants are masked during reset so nothing reaches the RAM while Reset_N is low.
    always_comb begin
        oor_0   = |Addr_0[29:ADDR_W];
        oor_1   = |Addr_1[29:ADDR_W];
        p1_prio = Req_1 && (wait_cnt >= 8'(MAX_WAIT));
        gnt_1   = Reset_N & Req_1 & (p1_prio | ~Req_0);
        gnt_0   = Reset_N & Req_0 & ~gnt_1;
        Ack_0   = gnt_0;
        Ack_1   = gnt_1;
        Err_0   = gnt_0 & oor_0;
        Err_1   = gnt_1 & oor_1;
    end

    always_comb begin
        Mem_Addr   = '0;
        Mem_Data_W = '0;
        Mem_En_R   = 1'b0;
        Mem_En_W   = 1'b0;
        if (gnt_0) begin
            Mem_Addr   = Addr_0[ADDR_W-1:0];
            Mem_Data_W = Data_W_0;
            Mem_En_W   = We_0 & ~oor_0;
            Mem_En_R   = ~We_0 & ~oor_0;
        end else if (gnt_1) begin
            Mem_Addr   = Addr_1[ADDR_W-1:0];
            Mem_Data_W = Data_W_1;
            Mem_En_W   = We_1 & ~oor_1;
            Mem_En_R   = ~We_1 & ~oor_1;
        end
    end

    // RAM q is only valid in the return cycle, so the returning port sees it directly
    // and the idle port shows the value captured at its last return.
    always_comb begin
        Rd_Valid_0 = tag_vld & ~tag_port;
        Rd_Valid_1 = tag_vld & tag_port;
        Data_R_0   = hold_0;
        Data_R_1   = hold_1;
        if (Rd_Valid_0) begin
            Data_R_0 = tag_err ? 32'h0 : Mem_Data_R;
        end
        if (Rd_Valid_1) begin
            Data_R_1 = tag_err ? 32'h0 : Mem_Data_R;
        end
    end

    always_ff @(posedge Clock or negedge Reset_N) begin
        if (!Reset_N) begin
            wait_cnt <= '0;
            tag_vld  <= 1'b0;
            tag_port <= 1'b0;
            tag_err  <= 1'b0;
            hold_0   <= '0;
            hold_1   <= '0;
        end else begin
            if (!Req_1 || gnt_1) begin
                wait_cnt <= '0;
            end else if (wait_cnt != 8'hFF) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            tag_vld  <= (gnt_0 & ~We_0) | (gnt_1 & ~We_1);
            tag_port <= gnt_1;
            tag_err  <= gnt_1 ? oor_1 : oor_0;
            hold_0   <= Data_R_0;
            hold_1   <= Data_R_1;
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - scoreboard bench for data_mem_arbiter
// Includes a registered-output RAM model driven by the Mem_* outputs.
module tb_data_mem_arbiter;

    logic        Clock = 1'b0;
    logic        Reset_N;
    logic        Req_0, We_0, Req_1, We_1;
    logic [29:0] Addr_0, Addr_1;
    logic [31:0] Data_W_0, Data_W_1;
    logic        Ack_0, Err_0, Rd_Valid_0, Ack_1, Err_1, Rd_Valid_1;
    logic [31:0] Data_R_0, Data_R_1;
    logic [11:0] Mem_Addr;
    logic        Mem_En_R, Mem_En_W;
    logic [31:0] Mem_Data_W, Mem_Data_R;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q0[$];
    exp_t exp_q1[$];

    logic [31:0] ram [0:4095];

    data_mem_arbiter #(.ADDR_W(12), .MAX_WAIT(8)) dut (
        .Clock(Clock), .Reset_N(Reset_N),
        .Req_0(Req_0), .Addr_0(Addr_0), .We_0(We_0), .Data_W_0(Data_W_0),
        .Ack_0(Ack_0), .Err_0(Err_0), .Rd_Valid_0(Rd_Valid_0), .Data_R_0(Data_R_0),
        .Req_1(Req_1), .Addr_1(Addr_1), .We_1(We_1), .Data_W_1(Data_W_1),
        .Ack_1(Ack_1), .Err_1(Err_1), .Rd_Valid_1(Rd_Valid_1), .Data_R_1(Data_R_1),
        .Mem_Addr(Mem_Addr), .Mem_En_R(Mem_En_R), .Mem_En_W(Mem_En_W),
        .Mem_Data_W(Mem_Data_W), .Mem_Data_R(Mem_Data_R)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) begin
        cyc <= cyc + 1;
        if (Mem_En_W) ram[Mem_Addr] <= Mem_Data_W;
        if (Mem_En_R) Mem_Data_R <= ram[Mem_Addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input bit port, input logic [31:0] data);
        exp_t e;
        e.cyc  = cyc + 1;
        e.data = data;
        if (port) exp_q1.push_back(e);
        else      exp_q0.push_back(e);
    endtask

    // Monitor: pops an expectation whenever a port presents read data.
    always @(negedge Clock) begin
        exp_t e;
        check("ack_exclusive", {31'b0, Ack_0 & Ack_1}, 32'h0);
        if (Rd_Valid_0) begin
            if (exp_q0.size() == 0) begin
                check("spurious_rd_valid_0", {31'b0, Rd_Valid_0}, 32'h0);
            end else begin
                e = exp_q0.pop_front();
                check("rd_cycle_0", e.cyc == cyc ? 32'h1 : 32'h0, 32'h1);
                check("data_r_0", Data_R_0, e.data);
            end
        end
        if (Rd_Valid_1) begin
            if (exp_q1.size() == 0) begin
                check("spurious_rd_valid_1", {31'b0, Rd_Valid_1}, 32'h0);
            end else begin
                e = exp_q1.pop_front();
                check("rd_cycle_1", e.cyc == cyc ? 32'h1 : 32'h0, 32'h1);
                check("data_r_1", Data_R_1, e.data);
            end
        end
    end

    // Issues one request starting just after a rising edge; expects it granted this cycle.
    task automatic do_req(input bit port, input bit we, input logic [29:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rd);
        logic oor;
        oor = (addr[29:12] != 18'h0);
        if (port) begin
            Req_1 = 1'b1; We_1 = we; Addr_1 = addr; Data_W_1 = wdata;
        end else begin
            Req_0 = 1'b1; We_0 = we; Addr_0 = addr; Data_W_0 = wdata;
        end
        @(negedge Clock);
        check("ack_0", {31'b0, Ack_0}, {31'b0, ~port});
        check("ack_1", {31'b0, Ack_1}, {31'b0, port});
        check("err", {31'b0, port ? Err_1 : Err_0}, {31'b0, oor});
        check("mem_en_w", {31'b0, Mem_En_W}, {31'b0, we & ~oor});
        check("mem_en_r", {31'b0, Mem_En_R}, {31'b0, ~we & ~oor});
        if (!oor) check("mem_addr", {20'b0, Mem_Addr}, {20'b0, addr[11:0]});
        if (we && !oor) check("mem_data_w", Mem_Data_W, wdata);
        if (!we) push_exp(port, oor ? 32'h0 : exp_rd);
        @(posedge Clock);
        #1;
        if (port) Req_1 = 1'b0;
        else      Req_0 = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        bit exp1;
        Reset_N = 1'b0;
        Req_0 = 1'b1; We_0 = 1'b1; Addr_0 = 30'd5; Data_W_0 = 32'hDEADBEEF;
        Req_1 = 1'b1; We_1 = 1'b0; Addr_1 = 30'd7; Data_W_1 = 32'h0;

        repeat (3) begin
            @(negedge Clock);
            check("rst_ack_0", {31'b0, Ack_0}, 32'h0);
            check("rst_ack_1", {31'b0, Ack_1}, 32'h0);
            check("rst_mem_en_w", {31'b0, Mem_En_W}, 32'h0);
            check("rst_mem_en_r", {31'b0, Mem_En_R}, 32'h0);
            check("rst_mem_addr", {20'b0, Mem_Addr}, 32'h0);
            check("rst_rd_valid", {30'b0, Rd_Valid_1, Rd_Valid_0}, 32'h0);
            check("rst_data_r_0", Data_R_0, 32'h0);
            check("rst_data_r_1", Data_R_1, 32'h0);
        end
        @(posedge Clock);
        #1;
        Reset_N = 1'b1;

        // Port 0 wins first with port 1 also requesting, then read-after-write.
        do_req(0, 1, 30'd5, 32'hDEADBEEF, 32'h0);
        Req_1 = 1'b0;
        do_req(0, 0, 30'd5, 32'h0, 32'hDEADBEEF);

        do_req(0, 1, 30'd1, 32'd11, 32'h0);
        do_req(1, 1, 30'd2, 32'd22, 32'h0);
        do_req(1, 1, 30'd4095, 32'hA5A50F0F, 32'h0);
        do_req(0, 0, 30'd4095, 32'h0, 32'hA5A50F0F);

        // Out of range: read returns zero, write must not alias into address 4095.
        do_req(1, 0, 30'h1000, 32'h0, 32'h0);
        do_req(0, 1, 30'h3FFFFFFF, 32'h12345678, 32'h0);
        do_req(1, 0, 30'd4095, 32'h0, 32'hA5A50F0F);

        // Interleaved reads, then the idle port keeps its last data.
        do_req(0, 0, 30'd1, 32'h0, 32'd11);
        do_req(1, 0, 30'd2, 32'h0, 32'd22);
        @(negedge Clock);
        check("hold_data_r_0", Data_R_0, 32'd11);
        @(negedge Clock);
        check("hold_data_r_0b", Data_R_0, 32'd11);
        check("hold_data_r_1", Data_R_1, 32'd22);
        @(posedge Clock);
        #1;

        // Starvation: both held, port 1 takes every ninth cycle.
        Req_0 = 1'b1; We_0 = 1'b0; Addr_0 = 30'd1;
        Req_1 = 1'b1; We_1 = 1'b0; Addr_1 = 30'd2;
        for (int i = 0; i < 18; i++) begin
            @(negedge Clock);
            exp1 = (i % 9 == 8);
            check("starve_ack_0", {31'b0, Ack_0}, {31'b0, ~exp1});
            check("starve_ack_1", {31'b0, Ack_1}, {31'b0, exp1});
            if (exp1) push_exp(1, 32'd22);
            else      push_exp(0, 32'd11);
            @(posedge Clock);
            #1;
        end
        Req_0 = 1'b0; Req_1 = 1'b0;
        repeat (2) @(posedge Clock);
        #1;

        // Reset between a read grant and its return discards the pending read.
        Req_0 = 1'b1; We_0 = 1'b0; Addr_0 = 30'd5;
        @(negedge Clock);
        check("midrst_ack_0", {31'b0, Ack_0}, 32'h1);
        @(posedge Clock);
        #1;
        Reset_N = 1'b0;
        Req_0 = 1'b0;
        @(negedge Clock);
        check("midrst_rd_valid_0", {31'b0, Rd_Valid_0}, 32'h0);
        check("midrst_data_r_0", Data_R_0, 32'h0);
        check("midrst_data_r_1", Data_R_1, 32'h0);
        @(posedge Clock);
        #1;
        Reset_N = 1'b1;
        repeat (3) @(negedge Clock);
        check("post_rst_rd_valid", {30'b0, Rd_Valid_1, Rd_Valid_0}, 32'h0);

        check("exp_q0_drained", exp_q0.size(), 32'h0);
        check("exp_q1_drained", exp_q1.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
